avmm_cmd_master: RTL and testbench
==================================

AVMM_CMD_MASTER -- requirements
Module: avmm_cmd_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning max cycles a transfer may stall on avm_waitrequest (0 = no timeout; legal 0..65535).
REQ-002 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port cmd_valid  in  1  command present.
REQ-005 SHALL have port cmd_ready  out  1  command accepted when cmd_valid and cmd_ready both high at the clock edge.
REQ-006 SHALL have port cmd_write  in  1  1 = write, 0 = read.
REQ-007 SHALL have port cmd_address  in  8  target address.
REQ-008 SHALL have port cmd_writedata  in  16  write data (ignored for reads).
REQ-009 SHALL have port avm_address  out  8  Avalon-MM address to downstream slave.
REQ-010 SHALL have port avm_read  out  1  Avalon-MM read strobe.
REQ-011 SHALL have port avm_write  out  1  Avalon-MM write strobe.
REQ-012 SHALL have port avm_writedata  out  16  Avalon-MM write data.
REQ-013 SHALL have port avm_readdata  in  16  read data, valid in the cycle avm_read high and avm_waitrequest low (zero read latency).
REQ-014 SHALL have port avm_waitrequest  in  1  slave stall.
REQ-015 SHALL have port rsp_valid  out  1  response present.
REQ-016 SHALL have port rsp_ready  in  1  response consumed when rsp_valid and rsp_ready both high at the clock edge.
REQ-017 SHALL have port rsp_data  out  16  captured read data, 0 on timeout.
REQ-018 SHALL have port rsp_address  out  8  address of the completed transfer.
REQ-019 SHALL have port rsp_timeout  out  1  1 = transfer aborted by timeout.

Function
REQ-020 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-021 IDLE: cmd_ready=1, avm_read=avm_write=0, rsp_valid=0; on accept, register cmd_address/cmd_writedata onto avm_address/avm_writedata, assert avm_read or avm_write per cmd_write, clear stall counter, go ACCESS.
REQ-022 ACCESS: cmd_ready=0; avm_address, avm_writedata, avm_read, avm_write SHALL stay constant while avm_waitrequest=1.
REQ-023 ACCESS, edge with avm_waitrequest=0, read: capture avm_readdata into rsp_data, avm_address into rsp_address, rsp_timeout=0, deassert avm_read, go RESP.
REQ-024 ACCESS, edge with avm_waitrequest=0, write: deassert avm_write, go IDLE; writes produce no response.
REQ-025 ACCESS, edge with avm_waitrequest=1: stall counter (16 bit, saturating) increments; if TIMEOUT!=0 and counter==TIMEOUT-1, deassert strobes, set rsp_data=0, rsp_address=avm_address, rsp_timeout=1, go RESP (applies to reads and writes).
REQ-026 Timeout latency: a transfer stalled continuously is aborted at the TIMEOUT-th edge after strobe assertion; a release on that same edge completes normally (completion wins over timeout).
REQ-027 RESP: rsp_valid=1, rsp_* held stable until handshake; on rsp_ready go IDLE.
REQ-028 Latency: command accept to strobe = 1 cycle; unstalled read yields rsp_valid 2 cycles after accept; minimum spacing between accepted commands = 2 cycles (write) / 3 cycles (read, rsp_ready held 1).
REQ-029 At most one transfer outstanding; cmd_ready SHALL be 0 in ACCESS and RESP.
REQ-030 avm_read and avm_write SHALL never be high simultaneously.

Reset
REQ-031 While rst=1, and immediately on its assertion: state=IDLE, avm_read=avm_write=0, avm_address=0, avm_writedata=0, rsp_valid=0, rsp_data=0, rsp_address=0, rsp_timeout=0, stall counter=0, cmd_ready=0.
REQ-032 Reset mid-ACCESS SHALL drop strobes asynchronously and discard the transfer; no response produced.
REQ-033 cmd_ready SHALL first assert on the first clock edge after rst deasserts.

Verification
REQ-034 Read addr 0x01, echo slave, waitrequest low -> avm_read one cycle, rsp_valid with rsp_data=0x0001, rsp_address=0x01, rsp_timeout=0.
REQ-035 Write addr 0x01 data 0xBEEF, waitrequest high 3 cycles -> avm_address/avm_writedata/avm_write stable 4 cycles, then deasserted, no rsp_valid.
REQ-036 Back-to-back reads 0x02, 0x03, 0x03 with rsp_ready held low 2 cycles each -> rsp_* stable until handshake, data 0x0002, 0x0003, 0x0003 in order, cmd_ready low throughout.
REQ-037 TIMEOUT=4, read with waitrequest stuck high -> strobe high exactly 4 cycles, rsp_timeout=1, rsp_data=0x0000; waitrequest released on 4th edge -> normal completion, rsp_timeout=0.
REQ-038 rst pulsed while avm_write high and waitrequest high -> avm_write low within same cycle, rsp_valid never asserts, next command after reset executes normally.

Source files
------------

// File: rtl/avmm_cmd_master_if.sv
// Bundles the command, Avalon-MM master and response signals of avmm_cmd_master.
// The master modport is the block's view; the slave modport is the environment's view.
interface avmm_cmd_master_if;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;

    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_address;
    logic [DW-1:0] cmd_writedata;

    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic [DW-1:0] avm_readdata;
    logic          avm_waitrequest;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_address;
    logic          rsp_timeout;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_writedata,
        input  avm_readdata, avm_waitrequest, rsp_ready,
        output cmd_ready, avm_address, avm_read, avm_write, avm_writedata,
        output rsp_valid, rsp_data, rsp_address, rsp_timeout
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_writedata,
        output avm_readdata, avm_waitrequest, rsp_ready,
        input  cmd_ready, avm_address, avm_read, avm_write, avm_writedata,
        input  rsp_valid, rsp_data, rsp_address, rsp_timeout
    );
endinterface

// File: rtl/avmm_cmd_master.sv
// Single-outstanding command-to-Avalon-MM master with stall timeout.
// Reads return a response (data or timeout); writes only respond when they time out.
module avmm_cmd_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    avmm_cmd_master_if.master bus
);
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic          TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] STALL_LAST = (TIMEOUT == 0) ? CW'(0) : CW'(TIMEOUT - 1);

    logic [1:0]    state_q,         state_d;
    logic          cmd_ready_q,     cmd_ready_d;
    logic [AW-1:0] avm_address_q,   avm_address_d;
    logic [DW-1:0] avm_writedata_q, avm_writedata_d;
    logic          avm_read_q,      avm_read_d;
    logic          avm_write_q,     avm_write_d;
    logic          rsp_valid_q,     rsp_valid_d;
    logic [DW-1:0] rsp_data_q,      rsp_data_d;
    logic [AW-1:0] rsp_address_q,   rsp_address_d;
    logic          rsp_timeout_q,   rsp_timeout_d;
    logic [CW-1:0] stall_cnt_q,     stall_cnt_d;

    // State and all registered outputs; reset drops strobes immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            cmd_ready_q     <= 1'b0;
            avm_address_q   <= '0;
            avm_writedata_q <= '0;
            avm_read_q      <= 1'b0;
            avm_write_q     <= 1'b0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_address_q   <= '0;
            rsp_timeout_q   <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            cmd_ready_q     <= cmd_ready_d;
            avm_address_q   <= avm_address_d;
            avm_writedata_q <= avm_writedata_d;
            avm_read_q      <= avm_read_d;
            avm_write_q     <= avm_write_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_data_q      <= rsp_data_d;
            rsp_address_q   <= rsp_address_d;
            rsp_timeout_q   <= rsp_timeout_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state_q;
        cmd_ready_d     = cmd_ready_q;
        avm_address_d   = avm_address_q;
        avm_writedata_d = avm_writedata_q;
        avm_read_d      = avm_read_q;
        avm_write_d     = avm_write_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_data_d      = rsp_data_q;
        rsp_address_d   = rsp_address_q;
        rsp_timeout_d   = rsp_timeout_q;
        stall_cnt_d     = stall_cnt_q;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    state_d         = S_ACCESS;
                    cmd_ready_d     = 1'b0;
                    avm_address_d   = bus.cmd_address;
                    avm_writedata_d = bus.cmd_writedata;
                    avm_read_d      = !bus.cmd_write;
                    avm_write_d     = bus.cmd_write;
                    stall_cnt_d     = '0;
                end
            end

            S_ACCESS: begin
                if (!bus.avm_waitrequest) begin
                    avm_read_d  = 1'b0;
                    avm_write_d = 1'b0;
                    if (avm_read_q) begin
                        state_d       = S_RESP;
                        rsp_valid_d   = 1'b1;
                        rsp_data_d    = bus.avm_readdata;
                        rsp_address_d = avm_address_q;
                        rsp_timeout_d = 1'b0;
                    end else begin
                        state_d     = S_IDLE;
                        cmd_ready_d = 1'b1;
                    end
                end else begin
                    stall_cnt_d = (stall_cnt_q == '1) ? stall_cnt_q : stall_cnt_q + CW'(1);
                    // Release on the same edge takes the branch above, so completion beats timeout.
                    if (TIMEOUT_EN && (stall_cnt_q == STALL_LAST)) begin
                        state_d       = S_RESP;
                        avm_read_d    = 1'b0;
                        avm_write_d   = 1'b0;
                        rsp_valid_d   = 1'b1;
                        rsp_data_d    = '0;
                        rsp_address_d = avm_address_q;
                        rsp_timeout_d = 1'b1;
                    end
                end
            end

            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end

            default: begin
                state_d     = S_IDLE;
                cmd_ready_d = 1'b0;
                avm_read_d  = 1'b0;
                avm_write_d = 1'b0;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.avm_address   = avm_address_q;
    assign bus.avm_writedata = avm_writedata_q;
    assign bus.avm_read      = avm_read_q;
    assign bus.avm_write     = avm_write_q;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_address   = rsp_address_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
endmodule

// File: tb/tb_avmm_cmd_master.sv
// Directed bench for avmm_cmd_master (TIMEOUT=4) against an address-echo slave.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_avmm_cmd_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;

    avmm_cmd_master_if bus ();

    avmm_cmd_master #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Echo slave: read data is the current address, zero read latency.
    assign bus.avm_readdata = {8'h00, bus.avm_address};

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        int          waits;     // cycles waitrequest is held high after the strobe rises
        int          hold;      // cycles rsp_ready is held low while rsp_valid is up
        int          exp_cyc;   // expected number of cycles the strobe stays high
        logic        exp_rsp;
        logic [15:0] exp_data;
        logic        exp_to;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int guard;
        guard = 0;
        while (!bus.cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk($sformatf("v%0d_cmd_ready", idx), 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid       = 1'b1;
        bus.cmd_write       = v.wr;
        bus.cmd_address     = v.addr;
        bus.cmd_writedata   = v.wdata;
        bus.avm_waitrequest = (v.waits != 0);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.avm_waitrequest = (c < v.waits);
            if (!(bus.avm_read || bus.avm_write)) break;
            n++;
            chk($sformatf("v%0d_strobe_addr", idx), {bus.avm_read, bus.avm_write, bus.cmd_ready, bus.avm_address},
                {!v.wr, v.wr, 1'b0, v.addr});
            if (v.wr) chk($sformatf("v%0d_wdata", idx), 32'(bus.avm_writedata), 32'(v.wdata));
        end
        bus.avm_waitrequest = 1'b0;
        chk($sformatf("v%0d_strobe_cycles", idx), 32'(n), 32'(v.exp_cyc));
        if (v.exp_rsp) begin
            for (int h = 0; h <= v.hold; h++) begin
                if (h > 0) @(negedge clk);
                chk($sformatf("v%0d_rsp", idx),
                    {bus.rsp_valid, bus.cmd_ready, bus.rsp_timeout, bus.rsp_address, bus.rsp_data},
                    {1'b1, 1'b0, v.exp_to, v.addr, v.exp_data});
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            chk($sformatf("v%0d_after_hs", idx), {bus.rsp_valid, bus.cmd_ready}, {1'b0, 1'b1});
        end else begin
            chk($sformatf("v%0d_no_rsp", idx), {bus.rsp_valid, bus.cmd_ready}, {1'b0, 1'b1});
        end
    endtask

    // Mutual exclusion of the strobes is checked on every falling edge.
    always @(negedge clk) begin
        if (bus.avm_read && bus.avm_write) begin
            total++;
            $display("FAIL strobe_exclusive: read=1 write=1 expected at most one at %0t", $time);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        int seen;
        //          wr    addr   wdata     waits hold cyc rsp   data      to
        vecs[0] = '{1'b0, 8'h01, 16'h0000, 0,    0,   1,  1'b1, 16'h0001, 1'b0};
        vecs[1] = '{1'b1, 8'h01, 16'hBEEF, 3,    0,   4,  1'b0, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 8'h02, 16'h0000, 0,    2,   1,  1'b1, 16'h0002, 1'b0};
        vecs[3] = '{1'b0, 8'h03, 16'h0000, 0,    2,   1,  1'b1, 16'h0003, 1'b0};
        vecs[4] = '{1'b0, 8'h03, 16'h0000, 0,    2,   1,  1'b1, 16'h0003, 1'b0};
        vecs[5] = '{1'b0, 8'h40, 16'h0000, 10,   1,   4,  1'b1, 16'h0000, 1'b1};
        vecs[6] = '{1'b0, 8'h7F, 16'h0000, 3,    0,   4,  1'b1, 16'h007F, 1'b0};
        vecs[7] = '{1'b1, 8'h22, 16'hA5A5, 10,   0,   4,  1'b1, 16'h0000, 1'b1};
        vecs[8] = '{1'b1, 8'hFF, 16'h1234, 0,    0,   1,  1'b0, 16'h0000, 1'b0};
        vecs[9] = '{1'b0, 8'hFF, 16'h0000, 1,    0,   2,  1'b1, 16'h00FF, 1'b0};

        bus.cmd_valid       = 1'b0;
        bus.cmd_write       = 1'b0;
        bus.cmd_address     = '0;
        bus.cmd_writedata   = '0;
        bus.avm_waitrequest = 1'b0;
        bus.rsp_ready       = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_outputs", {bus.cmd_ready, bus.avm_read, bus.avm_write, bus.rsp_valid, bus.rsp_timeout},
            32'd0);
        chk("reset_avm_bus", {bus.avm_address, bus.avm_writedata}, 32'd0);
        chk("reset_rsp_bus", {bus.rsp_address, bus.rsp_data}, 32'd0);
        rst = 1'b0;
        #1 chk("ready_low_before_edge", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk);
        #1 chk("ready_first_edge", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Reset during a stalled write: strobe must drop before the next clock edge.
        @(negedge clk);
        bus.cmd_valid       = 1'b1;
        bus.cmd_write       = 1'b1;
        bus.cmd_address     = 8'h55;
        bus.cmd_writedata   = 16'hCAFE;
        bus.avm_waitrequest = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_write_high", 32'(bus.avm_write), 32'd1);
        #2 rst = 1'b1;
        #1 chk("rst_mid_async_drop", {bus.avm_write, bus.avm_read, bus.rsp_valid, bus.cmd_ready}, 32'd0);
        repeat (2) @(negedge clk);
        bus.avm_waitrequest = 1'b0;
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid || bus.avm_write) seen = 1;
        end
        chk("rst_mid_no_rsp", 32'(seen), 32'd0);
        run_vec(vecs[0], 10);
        run_vec(vecs[1], 11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
